rsa_core_arbiter: RTL and testbench
===================================

RSA_CORE_ARBITER -- requirements
Module: rsa_core_arbiter

Interface
REQ-001: Parameter WIDTH, default 8: bit width of message, modulus and result operands.
REQ-002: Parameter EXPW, default 10: bit width of the exponent operand.
REQ-003: Parameter TIMEOUT, default 255: maximum RUN-state cycles before the job is aborted.
REQ-004: The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
REQ-005: clk  input  1  clock; all state updates on rising edge.
REQ-006: rst  input  1  asynchronous active-high reset.
REQ-007: ena  input  1  global enable; when 0, all registers hold their value.
REQ-008: req  input  2  job request per requester, index 0 and 1.
REQ-009: msg0/msg1  input  WIDTH each  message operand per requester.
REQ-010: exp0/exp1  input  EXPW each  exponent operand per requester.
REQ-011: mod0/mod1  input  WIDTH each  modulus operand per requester.
REQ-012: gnt  output  2  one-hot grant, held from LOAD through DONE.
REQ-013: done  output  2  one-cycle completion pulse to the owner.
REQ-014: err  output  2  one-cycle timeout pulse to the owner.
REQ-015: result  output  WIDTH  last completed result, held until the next completion.
REQ-016: busy  output  1  high in any state other than IDLE.
REQ-017: core_run  output  1  0 holds the exponentiation core in reset; 1 lets it run.
REQ-018: core_msg/core_exp/core_mod  output  WIDTH/EXPW/WIDTH  latched operands driven to the core.
REQ-019: core_eoc  input  1  core end-of-computation, a level that stays high until core_run falls.
REQ-020: core_result  input  WIDTH  core output, valid while core_eoc=1.

Function
REQ-021: The FSM SHALL have states IDLE, LOAD, RUN, DONE and ABORT; every transition requires ena=1.
REQ-022: IDLE, no req bit set: stay in IDLE.
REQ-023: IDLE, any req bit set: select the owner by round-robin, latch that owner's operands into the core_* registers, assert its gnt bit, and move to LOAD.
REQ-024: Round-robin rule: when both req bits are set, the requester not granted last wins; the pointer is updated on every grant.
REQ-025: LOAD: core_run=0 for exactly one cycle so the core resets with stable operands, then move to RUN.
REQ-026: RUN: core_run=1; the timeout counter clears on entry to RUN and increments by 1 each enabled cycle.
REQ-027: RUN with core_eoc=1: register core_result into result and move to DONE.
REQ-028: RUN, counter reaches TIMEOUT with core_eoc=0: move to ABORT; result is left unchanged.
REQ-029: If core_eoc=1 in the same cycle the counter reaches TIMEOUT, core_eoc SHALL win and the block moves to DONE.
REQ-030: DONE: drive done[owner]=1 for one cycle with core_run=0; gnt deasserts on exit; next state is IDLE.
REQ-031: ABORT: drive err[owner]=1 for one cycle with core_run=0; gnt deasserts on exit; next state is IDLE.
REQ-032: Operand inputs and req SHALL be ignored after the grant; deasserting req mid-job does not cancel the job.
REQ-033: Latency: grant to core_run=1 is 1 cycle; core_eoc to done pulse is 1 cycle; DONE/ABORT to next grant is at least 1 IDLE cycle.
REQ-034: gnt, done and err SHALL each be one-hot or zero at all times; done and err are never high together.
REQ-035: The timeout counter SHALL be wide enough to hold TIMEOUT and SHALL never wrap.

Reset
REQ-036: While rst=1, and regardless of ena: state=IDLE, RR pointer favours requester 0, gnt=0, done=0, err=0, result=0, busy=0, core_run=0, core_* operand registers=0, counter=0.
REQ-037: rst asserted mid-job SHALL abort silently: no done or err pulse, and core_run falls asynchronously.

Verification
REQ-038: req=01 with msg0=5, exp0=3, mod0=13; core model asserts eoc after 40 RUN cycles with result 8 -> gnt=01, one LOAD cycle, result=8, done=01 pulse for one cycle.
REQ-039: req=11 held for two back-to-back jobs -> first grant goes to requester 0, second to requester 1, with an IDLE cycle between the jobs.
REQ-040: Core never asserts eoc with TIMEOUT=255 -> err pulse exactly 255 RUN cycles after RUN entry, result unchanged, return to IDLE.
REQ-041: core_eoc rises on the same cycle the counter hits TIMEOUT -> done pulse, no err.
REQ-042: ena=0 for 10 cycles mid-RUN -> state, counter and outputs frozen; completion occurs 10 cycles later than without the stall.
REQ-043: rst pulsed during RUN -> all outputs at reset values immediately, no done or err pulse; a new request is serviced normally afterwards.

Source files
------------

// File: rtl/rsa_core_arbiter.sv
// Two-requester round-robin arbiter in front of a modular exponentiation core.
// The block latches the winning requester's operands and sequences the core
// through reset, run and completion. A RUN-state watchdog aborts jobs that
// never finish.
module rsa_core_arbiter #(
  parameter int WIDTH   = 8,
  parameter int EXPW    = 10,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] msg0,
  input  logic [WIDTH-1:0] msg1,
  input  logic [EXPW-1:0]  exp0,
  input  logic [EXPW-1:0]  exp1,
  input  logic [WIDTH-1:0] mod0,
  input  logic [WIDTH-1:0] mod1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [1:0]       err,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             core_run,
  output logic [WIDTH-1:0] core_msg,
  output logic [EXPW-1:0]  core_exp,
  output logic [WIDTH-1:0] core_mod,
  input  logic             core_eoc,
  input  logic [WIDTH-1:0] core_result
);

  // Counter is sized to hold TIMEOUT itself, so it never wraps.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Count value seen in the last allowed RUN cycle; the increment in that
  // cycle brings the counter to TIMEOUT, which ends the job.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;          // 1: requester 1 wins a tie
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       err_q, err_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             run_q, run_d;
  logic [WIDTH-1:0] msg_q, msg_d;
  logic [EXPW-1:0]  exp_q, exp_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sel;

  // Next-state and output computation for the job sequencer.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    done_d   = 2'b00;
    err_d    = 2'b00;
    result_d = result_q;
    run_d    = run_q;
    msg_d    = msg_q;
    exp_d    = exp_q;
    mod_d    = mod_q;
    cnt_d    = cnt_q;
    sel      = (req == 2'b11) ? rr_q : req[1];

    unique case (state_q)
      S_IDLE: begin
        run_d = 1'b0;
        if (|req) begin
          gnt_d   = sel ? 2'b10 : 2'b01;
          rr_d    = ~sel;
          msg_d   = sel ? msg1 : msg0;
          exp_d   = sel ? exp1 : exp0;
          mod_d   = sel ? mod1 : mod0;
          state_d = S_LOAD;
        end
      end
      // Core is still held in reset for this one cycle, with operands stable.
      S_LOAD: begin
        run_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_RUN;
      end
      // Completion takes priority over the watchdog in the same cycle.
      S_RUN: begin
        if (core_eoc) begin
          result_d = core_result;
          run_d    = 1'b0;
          done_d   = gnt_q;
          state_d  = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = cnt_q + 1'b1;
          run_d   = 1'b0;
          err_d   = gnt_q;
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE, S_ABORT: begin
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        run_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; ena=0 freezes everything, reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_q     <= 1'b0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      result_q <= '0;
      run_q    <= 1'b0;
      msg_q    <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      cnt_q    <= '0;
    end else if (ena) begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
      run_q    <= run_d;
      msg_q    <= msg_d;
      exp_q    <= exp_d;
      mod_q    <= mod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign result   = result_q;
  assign busy     = (state_q != S_IDLE);
  assign core_run = run_q;
  assign core_msg = msg_q;
  assign core_exp = exp_q;
  assign core_mod = mod_q;

endmodule

// File: tb/tb_rsa_core_arbiter.sv
// Directed bench for rsa_core_arbiter with a behavioural core model and a
// scoreboard of expected job outcomes.
module tb_rsa_core_arbiter;
  localparam int W  = 8;
  localparam int E  = 10;
  localparam int TO = 255;

  logic         clk = 1'b0;
  logic         rst, ena;
  logic [1:0]   req;
  logic [W-1:0] msg0, msg1, mod0, mod1;
  logic [E-1:0] exp0, exp1;
  logic [1:0]   gnt, done, err;
  logic [W-1:0] result;
  logic         busy, core_run;
  logic [W-1:0] core_msg, core_mod;
  logic [E-1:0] core_exp;
  logic         core_eoc;
  logic [W-1:0] core_result;

  rsa_core_arbiter #(.WIDTH(W), .EXPW(E), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req),
    .msg0(msg0), .msg1(msg1), .exp0(exp0), .exp1(exp1),
    .mod0(mod0), .mod1(mod1),
    .gnt(gnt), .done(done), .err(err), .result(result), .busy(busy),
    .core_run(core_run), .core_msg(core_msg), .core_exp(core_exp),
    .core_mod(core_mod), .core_eoc(core_eoc), .core_result(core_result)
  );

  always #5 clk = ~clk;

  // Core model: counts enabled cycles while running, then holds eoc high
  // until core_run drops.
  int cm_cnt = 0;
  int cm_delay = 1 << 30;
  always @(posedge clk) begin
    if (!core_run) cm_cnt <= 0;
    else if (ena)  cm_cnt <= cm_cnt + 1;
  end
  assign core_eoc = core_run && (cm_cnt >= cm_delay);

  typedef struct {
    int           owner;
    bit           is_err;
    logic [W-1:0] res;
    int           lat;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int passed = 0;
  logic [W-1:0] last_res = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // One job: request, check grant/operands, wait for the outcome, compare
  // against the scoreboard. dly<0 means the core never finishes.
  task automatic job(input string nm, input logic [1:0] r, input int owner,
                     input int dly, input bit hold, input int stall_at,
                     input logic [W-1:0] cres);
    exp_t e;
    int n;
    bit seen;
    logic [W-1:0] s_msg;
    logic [E+W-1:0] s_em;
    e.owner  = owner;
    e.is_err = (dly < 0);
    e.res    = e.is_err ? last_res : cres;
    e.lat    = (e.is_err ? TO : dly + 1) + ((stall_at >= 0) ? 10 : 0);
    sb.push_back(e);
    cm_delay    = (dly < 0) ? (1 << 30) : dly;
    core_result = cres;
    req = r;
    n = 0;
    while (gnt == 2'b00 && n < 5) begin @(negedge clk); n++; end
    s_msg = owner ? msg1 : msg0;
    s_em  = owner ? {exp1, mod1} : {exp0, mod0};
    chk({nm, ".gnt"}, gnt, owner ? 2 : 1);
    chk({nm, ".load_run"}, core_run, 0);
    chk({nm, ".msg"}, core_msg, s_msg);
    chk({nm, ".expmod"}, {core_exp, core_mod}, s_em);
    if (!hold) req = 2'b00;
    msg0 = msg0 ^ 8'hff;
    msg1 = msg1 ^ 8'hff;
    @(negedge clk);
    chk({nm, ".run"}, core_run, 1);
    chk({nm, ".busy"}, busy, 1);
    chk({nm, ".msg_held"}, core_msg, s_msg);
    n = 0;
    seen = 0;
    while (!seen && n < 600) begin
      if (n == stall_at) begin
        ena = 1'b0;
        repeat (10) @(negedge clk);
        n += 10;
        chk({nm, ".stall_run"}, {core_run, busy, gnt, done, err}, {1'b1, 1'b1, (owner ? 2'b10 : 2'b01), 4'b0000});
        ena = 1'b1;
      end
      @(negedge clk);
      n++;
      if (done != 2'b00 || err != 2'b00) seen = 1;
    end
    chk({nm, ".seen"}, seen, 1);
    e = sb.pop_front();
    chk({nm, ".lat"}, n, e.lat);
    chk({nm, ".done"}, done, e.is_err ? 0 : (1 << e.owner));
    chk({nm, ".err"}, err, e.is_err ? (1 << e.owner) : 0);
    chk({nm, ".result"}, result, e.res);
    if (!e.is_err) last_res = e.res;
    @(negedge clk);
    chk({nm, ".idle"}, {gnt, done, err, busy, core_run}, 8'h00);
  endtask

  initial begin
    int n;
    bit spur;
    rst = 1'b1; ena = 1'b0; req = 2'b11;
    msg0 = 8'h21; msg1 = 8'h42; exp0 = 10'h011; exp1 = 10'h022;
    mod0 = 8'h31; mod1 = 8'h52; core_result = '0;
    repeat (2) @(negedge clk);
    chk("rst.outs", {gnt, done, err, busy, core_run}, 8'h00);
    chk("rst.result", result, 0);
    chk("rst.ops", {core_msg, core_exp, core_mod}, 0);
    rst = 1'b0; ena = 1'b1; req = 2'b00;
    @(negedge clk);

    // Held 11 request: owner 0 first, then owner 1 after an IDLE cycle.
    job("b2b0", 2'b11, 0, 5, 1'b1, -1, 8'h11);
    job("b2b1", 2'b11, 1, 7, 1'b0, -1, 8'h22);

    msg0 = 8'd5; exp0 = 10'd3; mod0 = 8'd13;
    job("basic", 2'b01, 0, 40, 1'b0, -1, 8'd8);
    job("tmo", 2'b10, 1, -1, 1'b0, -1, 8'hee);
    job("tie", 2'b01, 0, TO - 1, 1'b0, -1, 8'h5a);
    job("stall", 2'b10, 1, 40, 1'b0, 20, 8'h77);

    // Reset in the middle of RUN.
    cm_delay = 40;
    req = 2'b01;
    n = 0;
    while (gnt == 2'b00 && n < 5) begin @(negedge clk); n++; end
    req = 2'b00;
    repeat (5) @(negedge clk);
    chk("mid.running", core_run, 1);
    rst = 1'b1;
    #1;
    chk("mid.outs", {gnt, done, err, busy, core_run}, 8'h00);
    chk("mid.result", result, 0);
    chk("mid.ops", {core_msg, core_exp, core_mod}, 0);
    last_res = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    spur = 0;
    repeat (60) begin
      @(negedge clk);
      if (done != 2'b00 || err != 2'b00 || busy) spur = 1;
    end
    chk("mid.quiet", spur, 0);
    job("post_rst", 2'b11, 0, 10, 1'b0, -1, 8'h3c);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
